// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversampling default
// and the baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // Clocks per oversampling tick, never below one.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        int div;
        div = clk_freq / (baud_rate * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, held at zero while clear is high.
module baud_tick_gen #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = !clear && (cnt_r == CNT_LAST);

    // Divider counter: wraps on tick, restarts from zero whenever cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear || tick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampled 8N1 receiver delivering 7-bit ASCII words and a write strobe to the keyboard FIFO,
// with framing-error pulse and sticky overrun flag.
module uart_rx import uart_pkg::*; #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       buf_full,
    output logic [6:0] rx_data,
    output logic       write,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] FULL_LAST = OS_W'(OVERSAMPLE - 1);

    logic             rx_meta_r, rx_sync_r;
    uart_state_t      state_r, state_s;
    logic [OS_W-1:0]  os_cnt_r, os_cnt_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic [6:0]       rx_data_r, rx_data_s;
    logic             write_r, write_s;
    logic             frame_err_r, frame_err_s;
    logic             overrun_r, overrun_s;
    logic             tick_s, clear_s;

    assign clear_s = (state_r == ST_IDLE);

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Next-state and datapath decisions; every sample happens on a tick that closes a count window.
    always_comb begin
        state_s     = state_r;
        os_cnt_s    = os_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        rx_data_s   = rx_data_r;
        write_s     = 1'b0;
        frame_err_s = 1'b0;
        overrun_s   = overrun_r;
        case (state_r)
            ST_IDLE: begin
                os_cnt_s  = {OS_W{1'b0}};
                bit_cnt_s = 3'd0;
                if (!rx_sync_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (os_cnt_r == HALF_LAST)) begin
                    os_cnt_s = {OS_W{1'b0}};
                    state_s  = rx_sync_r ? ST_IDLE : ST_DATA;
                end else if (tick_s) begin
                    os_cnt_s = os_cnt_r + OS_W'(1);
                end else begin
                    os_cnt_s = os_cnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s && (os_cnt_r == FULL_LAST)) begin
                    os_cnt_s  = {OS_W{1'b0}};
                    shift_s   = {rx_sync_r, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    state_s   = (bit_cnt_r == 3'd7) ? ST_STOP : ST_DATA;
                end else if (tick_s) begin
                    os_cnt_s = os_cnt_r + OS_W'(1);
                end else begin
                    os_cnt_s = os_cnt_r;
                end
            end
            ST_STOP: begin
                if (tick_s && (os_cnt_r == FULL_LAST)) begin
                    os_cnt_s = {OS_W{1'b0}};
                    if (rx_sync_r && buf_full) begin
                        overrun_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else if (rx_sync_r) begin
                        rx_data_s = shift_r[6:0];
                        write_s   = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = ST_BREAK;
                    end
                end else if (tick_s) begin
                    os_cnt_s = os_cnt_r + OS_W'(1);
                end else begin
                    os_cnt_s = os_cnt_r;
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before another frame may start.
                if (rx_sync_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Synchronizer, state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r   <= 1'b1;
            rx_sync_r   <= 1'b1;
            state_r     <= ST_IDLE;
            os_cnt_r    <= {OS_W{1'b0}};
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'd0;
            rx_data_r   <= 7'd0;
            write_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            rx_meta_r   <= rx;
            rx_sync_r   <= rx_meta_r;
            state_r     <= state_s;
            os_cnt_r    <= os_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            rx_data_r   <= rx_data_s;
            write_r     <= write_s;
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
        end
    end

    assign rx_data   = rx_data_r;
    assign write     = write_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 64 clocks per bit, with a frame-level reference model.
module tb_uart_rx;

    localparam int CLK_FREQ  = 7_372_800;
    localparam int BAUD_RATE = 115200;
    localparam int BIT_CYC   = 64;
    localparam int FRAME_CYC = 10 * BIT_CYC;
    localparam int LATENCY   = 2 + 152 * 4 + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       buf_full;
    logic [6:0] rx_data;
    logic       write;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    logic [6:0] got_q[$];
    int         got_t[$];

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .buf_full  (buf_full),
        .rx_data   (rx_data),
        .write     (write),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (write) begin
            got_q.push_back(rx_data);
            got_t.push_back(cyc);
        end
        if (frame_err) fe_cnt++;
        if (write && frame_err) both_cnt++;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive the first ncyc clocks of a serial bit pattern, LSB first.
    task automatic send_bits(input logic [9:0] bits, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rx = bits[i / BIT_CYC];
            if (i == 0) fall_cyc = cyc;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bits({stop, b, 1'b0}, FRAME_CYC);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; buf_full = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rx_data !== 7'd0) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b want 0", write); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        idle(10);
    endtask

    task automatic test_basic();
        int base = got_q.size();
        int fe0 = fe_cnt;
        send_frame(8'h41, 1'b1);
        idle(40);
        n_checks++;
        if (got_q.size() != base + 1) begin
            n_fail++; $display("FAIL basic_count got %0d want 1", got_q.size() - base);
        end else begin
            n_checks++; if (got_q[base] !== 7'h41) begin n_fail++; $display("FAIL basic_data got %h want 41", got_q[base]); end
            n_checks++;
            if ((got_t[base] - fall_cyc < LATENCY - 4) || (got_t[base] - fall_cyc > LATENCY + 4)) begin
                n_fail++; $display("FAIL basic_latency got %0d want %0d+-4", got_t[base] - fall_cyc, LATENCY);
            end
        end
        n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL basic_frame_err got %0d want 0", fe_cnt - fe0); end
    endtask

    task automatic test_false_start();
        int base = got_q.size();
        int fe0 = fe_cnt;
        send_bits(10'h000, 20);
        idle(200);
        n_checks++; if (got_q.size() != base) begin n_fail++; $display("FAIL false_start_write got %0d want 0", got_q.size() - base); end
        n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL false_start_fe got %0d want 0", fe_cnt - fe0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy got %b want 0", busy); end
    endtask

    task automatic test_frame_err();
        int base = got_q.size();
        int fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        send_bits(10'h000, FRAME_CYC);
        idle(64);
        n_checks++; if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL frame_err_count got %0d want 1", fe_cnt - fe0); end
        n_checks++; if (got_q.size() != base) begin n_fail++; $display("FAIL frame_err_write got %0d want 0", got_q.size() - base); end
        send_frame(8'h30, 1'b1);
        idle(40);
        n_checks++;
        if (got_q.size() != base + 1) begin
            n_fail++; $display("FAIL frame_err_recover_count got %0d want 1", got_q.size() - base);
        end else begin
            n_checks++; if (got_q[base] !== 7'h30) begin n_fail++; $display("FAIL frame_err_recover_data got %h want 30", got_q[base]); end
        end
    endtask

    task automatic test_overrun();
        int base = got_q.size();
        buf_full = 1'b1;
        send_frame(8'h7A, 1'b1);
        idle(40);
        buf_full = 1'b0;
        n_checks++; if (got_q.size() != base) begin n_fail++; $display("FAIL overrun_write got %0d want 0", got_q.size() - base); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b want 1", overrun); end
        send_frame(8'h31, 1'b1);
        idle(40);
        n_checks++;
        if (got_q.size() != base + 1) begin
            n_fail++; $display("FAIL overrun_next_count got %0d want 1", got_q.size() - base);
        end else begin
            n_checks++; if (got_q[base] !== 7'h31) begin n_fail++; $display("FAIL overrun_next_data got %h want 31", got_q[base]); end
        end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got %b want 1", overrun); end
    endtask

    task automatic test_mid_reset();
        int base;
        int fe0;
        send_bits({1'b1, 8'h48, 1'b0}, 5 * BIT_CYC + 20);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        n_checks++; if ({rx_data, write, frame_err, overrun, busy} !== 11'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs got %h want 000", {rx_data, write, frame_err, overrun, busy});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = got_q.size();
        fe0 = fe_cnt;
        idle(FRAME_CYC + 60);
        n_checks++; if ((got_q.size() != base) || (fe_cnt != fe0)) begin
            n_fail++; $display("FAIL mid_reset_strobe got %0d/%0d want 0/0", got_q.size() - base, fe_cnt - fe0);
        end
        send_frame(8'h0D, 1'b1);
        idle(40);
        n_checks++;
        if (got_q.size() != base + 1) begin
            n_fail++; $display("FAIL mid_reset_next_count got %0d want 1", got_q.size() - base);
        end else begin
            n_checks++; if (got_q[base] !== 7'h0D) begin n_fail++; $display("FAIL mid_reset_next_data got %h want 0d", got_q[base]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp [3];
        int base = got_q.size();
        exp[0] = 7'h48; exp[1] = 7'h69; exp[2] = 7'h41;
        send_frame(8'h48, 1'b1);
        send_frame(8'h69, 1'b1);
        send_frame(8'hC1, 1'b1);
        idle(40);
        n_checks++;
        if (got_q.size() != base + 3) begin
            n_fail++; $display("FAIL b2b_count got %0d want 3", got_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_q[base + i] !== exp[i]) begin
                    n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[base + i], exp[i]);
                end
            end
        end
    endtask

    // Random frames against a frame-level model: good stop + room -> word, good stop + full -> overrun, bad stop -> frame error.
    task automatic test_random();
        logic [6:0] exp_q[$];
        logic       exp_ovr = 1'b0;
        int         exp_fe = 0;
        int         base = got_q.size();
        int         fe0 = fe_cnt;
        logic [7:0] b;
        logic       bad, bf;
        for (int k = 0; k < 12; k++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            bf  = ($urandom_range(0, 3) == 0);
            buf_full = bf;
            send_frame(b, !bad);
            if (bad) begin
                exp_fe++;
                send_bits(10'h000, BIT_CYC);
                idle(4 + $urandom_range(0, 30));
            end else begin
                if (bf) exp_ovr = 1'b1;
                else exp_q.push_back(b[6:0]);
                idle($urandom_range(0, 30));
            end
        end
        buf_full = 1'b0;
        idle(40);
        n_checks++;
        if (got_q.size() - base != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[base + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[base + i], exp_q[i]);
                end
            end
        end
        n_checks++; if (fe_cnt - fe0 != exp_fe) begin n_fail++; $display("FAIL rand_frame_err got %0d want %0d", fe_cnt - fe0, exp_fe); end
        n_checks++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL rand_overrun got %b want %b", overrun, exp_ovr); end
        n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL write_and_frame_err got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
